// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the burst-capable on-chip RAM slave.
package onchip_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RBURST = 2'd2
    } state_e;

    // Longest burst the slave accepts for a given burstcount width.
    function automatic int unsigned max_burst(input int unsigned burst_w);
        return 32'd1 << (burst_w - 32'd1);
    endfunction

    // Even parity: stored bit makes the total count of ones in the lane even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Inferred single-port RAM with per-lane write enables and a registered read port.
module onchip_ram_core #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter              INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [LANES-1:0]         be,
    input  logic [LANES*LANE_W-1:0]  wdata,
    output logic [LANES*LANE_W-1:0]  q
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned WORD_W = LANES * LANE_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Power-up contents come from INIT_FILE through the memory preload flow; reset never clears them.
    if (INIT_FILE == "") begin : g_no_preload
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/onchip_ram_burst_slave.sv
// Pipelined, incrementing-burst Avalon-MM slave in front of an on-chip RAM.
// Optional byte parity storage/check is enabled by defining ONCHIP_RAM_PARITY_EN.
module onchip_ram_burst_slave
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned BURST_W      = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter              INIT_FILE    = "onchip_ram_burst_slave.hex"
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chipselect,
    input  logic [ADDR_W-1:0]    address,
    input  logic [BURST_W-1:0]   burstcount,
    input  logic                 read,
    input  logic                 write,
    input  logic [DATA_W-1:0]    writedata,
    input  logic [DATA_W/8-1:0]  byteenable,
    input  logic                 clken,
    input  logic                 reset_req,
    input  logic                 freeze,
    output logic                 waitrequest,
    output logic [DATA_W-1:0]    readdata,
    output logic                 readdatavalid,
    output logic                 parity_err
);
    localparam int unsigned NB        = DATA_W / 8;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int unsigned LANE_W    = 9;
`else
    localparam int unsigned LANE_W    = 8;
`endif
    localparam int unsigned RAM_W     = NB * LANE_W;
    localparam int unsigned MAX_BEATS = max_burst(BURST_W);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   rem_q, rem_d;
    logic [BURST_W-1:0]   beats;
    logic                 en;
    logic                 live;
    logic                 ram_we, ram_re;
    logic [ADDR_W-1:0]    ram_addr;
    logic [RAM_W-1:0]     ram_wdata;
    logic [RAM_W-1:0]     ram_q;
    logic [RAM_W-1:0]     out_word;
    logic [READ_LATENCY-1:0] vld_q;

    assign en   = clken & ~reset_req & ~freeze;
    assign live = en & reset_n;

    // Burst length seen by the FSM: 0 means 1, oversize bursts are clipped.
    always_comb begin
        if (burstcount == '0) begin
            beats = BURST_W'(1);
        end else if (burstcount > BURST_W'(MAX_BEATS)) begin
            beats = BURST_W'(MAX_BEATS);
        end else begin
            beats = burstcount;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // Next state, beat issue and handshake; nothing moves while disabled.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = addr_q;
        waitrequest = ~live | (state_q == RBURST);
        if (live) begin
            case (state_q)
                IDLE: begin
                    ram_addr = address;
                    if (chipselect && (write || read)) begin
                        ram_we = write;
                        ram_re = ~write;
                        addr_d = address + ADDR_W'(1);
                        rem_d  = beats - BURST_W'(1);
                        if (beats > BURST_W'(1)) begin
                            state_d = write ? WBURST : RBURST;
                        end
                    end
                end
                WBURST: begin
                    if (write) begin
                        ram_we = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                        rem_d  = rem_q - BURST_W'(1);
                        if (rem_q == BURST_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                RBURST: begin
                    ram_re = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ram_wdata = '0;
        for (int i = 0; i < int'(NB); i++) begin
`ifdef ONCHIP_RAM_PARITY_EN
            ram_wdata[i*LANE_W +: LANE_W] = {byte_parity(writedata[i*8 +: 8]), writedata[i*8 +: 8]};
`else
            ram_wdata[i*LANE_W +: LANE_W] = writedata[i*8 +: 8];
`endif
        end
    end

    onchip_ram_core #(
        .LANES     (NB),
        .LANE_W    (LANE_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .re      (ram_re),
        .addr    (ram_addr),
        .be      (byteenable),
        .wdata   (ram_wdata),
        .q       (ram_q)
    );

    // Valid pipe tracks issued beats; the data path optionally gets one extra stage.
    if (READ_LATENCY == 1) begin : g_lat1
        assign out_word = ram_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= '0;
            end else if (en) begin
                vld_q <= ram_re;
            end
        end
    end else begin : g_latn
        logic [RAM_W-1:0] out_q;
        assign out_word = out_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= '0;
                out_q <= '0;
            end else if (en) begin
                vld_q <= {vld_q[READ_LATENCY-2:0], ram_re};
                out_q <= ram_q;
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];

`ifdef ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] perr_lanes;
`endif

    always_comb begin
        readdata = '0;
`ifdef ONCHIP_RAM_PARITY_EN
        perr_lanes = '0;
`endif
        for (int i = 0; i < int'(NB); i++) begin
            readdata[i*8 +: 8] = out_word[i*LANE_W +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
            perr_lanes[i] = byte_parity(out_word[i*LANE_W +: 8]) ^ out_word[i*LANE_W + 8];
`endif
        end
    end

`ifdef ONCHIP_RAM_PARITY_EN
    assign parity_err = readdatavalid & (|perr_lanes);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_ram_burst_slave.sv
// Scoreboard bench for onchip_ram_burst_slave: one LAT=1 and one LAT=2 instance on a shared bus.
module tb_onchip_ram_burst_slave;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned NB      = DATA_W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n, chipselect, read, write, clken, reset_req, freeze;
    logic [ADDR_W-1:0]   address;
    logic [BURST_W-1:0]  burstcount;
    logic [DATA_W-1:0]   writedata;
    logic [NB-1:0]       byteenable;
    logic                waitrequest, readdatavalid, parity_err;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest2, readdatavalid2, parity_err2;
    logic [DATA_W-1:0]   readdata2;

    int checks = 0;
    int errors = 0;
    logic                perr_expect = 1'b0;
    logic [DATA_W-1:0]   mem_m [256];
    logic [DATA_W-1:0]   exp_q1 [$];
    logic [DATA_W-1:0]   exp_q2 [$];
    logic [DATA_W-1:0]   e1, e2;
    logic                en_tb;

    assign en_tb = clken & ~reset_req & ~freeze;

    onchip_ram_burst_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .READ_LATENCY(1), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .burstcount(burstcount), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .parity_err(parity_err)
    );

    onchip_ram_burst_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .READ_LATENCY(2), .INIT_FILE("")
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .burstcount(burstcount), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .waitrequest(waitrequest2), .readdata(readdata2), .readdatavalid(readdatavalid2),
        .parity_err(parity_err2)
    );

    // Beats are consumed only in enabled cycles; a held beat during a stall is not a new one.
    always @(negedge clk) begin
        if (reset_n && en_tb && readdatavalid) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL lat1_unexpected_beat: got %h, required no beat", readdata);
            end else begin
                e1 = exp_q1.pop_front();
                if (readdata !== e1) begin
                    errors++;
                    $display("FAIL lat1_data: got %h, required %h", readdata, e1);
                end
            end
            checks++;
            if (parity_err !== perr_expect) begin
                errors++;
                $display("FAIL lat1_parity_err: got %b, required %b", parity_err, perr_expect);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && en_tb && readdatavalid2) begin
            checks++;
            if (exp_q2.size() == 0) begin
                errors++;
                $display("FAIL lat2_unexpected_beat: got %h, required no beat", readdata2);
            end else begin
                e2 = exp_q2.pop_front();
                if (readdata2 !== e2) begin
                    errors++;
                    $display("FAIL lat2_data: got %h, required %h", readdata2, e2);
                end
            end
            checks++;
            if (parity_err2 !== perr_expect) begin
                errors++;
                $display("FAIL lat2_parity_err: got %b, required %b", parity_err2, perr_expect);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] a, input int n,
                               input logic [NB-1:0] be, input logic [DATA_W-1:0] base);
        logic [ADDR_W-1:0] ai;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        burstcount = BURST_W'(n);
        byteenable = be;
        for (int i = 0; i < n; i++) begin
            writedata = base + DATA_W'(i);
            ai = a + ADDR_W'(i);
            for (int b = 0; b < int'(NB); b++) begin
                if (be[b]) mem_m[ai][b*8 +: 8] = writedata[b*8 +: 8];
            end
            tick();
        end
        bus_idle();
        byteenable = '1;
    endtask

    task automatic read_cmd(input logic [ADDR_W-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q1.push_back(mem_m[a + ADDR_W'(i)]);
            exp_q2.push_back(mem_m[a + ADDR_W'(i)]);
        end
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        burstcount = BURST_W'(n);
        tick();
        bus_idle();
    endtask

    task automatic wait_drain(input string name);
        int budget = 40;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        tick();
        checks++;
        if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d/%0d beats outstanding, required 0/0", name, exp_q1.size(), exp_q2.size());
            exp_q1.delete();
            exp_q2.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
        bus_idle();
        address = '0; burstcount = BURST_W'(1); writedata = '0; byteenable = '1;
        repeat (3) tick();
        checks += 4;
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitrequest: got %b, required 1", waitrequest); end
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", readdatavalid); end
        if (readdata !== '0) begin errors++; $display("FAIL rst_readdata: got %h, required 0", readdata); end
        if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity_err: got %b, required 0", parity_err); end
        reset_n = 1'b1;
        tick();
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("FAIL idle_waitrequest: got %b, required 0", waitrequest); end
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] exp;
        exp = {16{8'hA5}};
        write_burst(8'h03, 1, '1, exp);
        read_cmd(8'h03, 1);
        checks += 4;
        if (readdatavalid !== 1'b1) begin errors++; $display("FAIL single_lat1_valid: got %b, required 1", readdatavalid); end
        if (readdata !== exp) begin errors++; $display("FAIL single_lat1_data: got %h, required %h", readdata, exp); end
        if (readdatavalid2 !== 1'b0) begin errors++; $display("FAIL single_lat2_early: got %b, required 0", readdatavalid2); end
        if (waitrequest !== 1'b0) begin errors++; $display("FAIL single_waitrequest: got %b, required 0", waitrequest); end
        tick();
        checks += 3;
        if (readdatavalid2 !== 1'b1) begin errors++; $display("FAIL single_lat2_valid: got %b, required 1", readdatavalid2); end
        if (readdata2 !== exp) begin errors++; $display("FAIL single_lat2_data: got %h, required %h", readdata2, exp); end
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL single_lat1_late: got %b, required 0", readdatavalid); end
        wait_drain("single");
    endtask

    task automatic test_burst_wrap();
        write_burst(8'hFE, 4, '1, 128'h1111_2222_3333_4444_5555_6666_7777_0000);
        read_cmd(8'hFE, 4);
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (readdatavalid !== 1'b1) begin errors++; $display("FAIL burst_gap beat %0d: valid %b, required 1", i, readdatavalid); end
            if (waitrequest !== (i < 3)) begin errors++; $display("FAIL burst_waitrequest beat %0d: got %b, required %b", i, waitrequest, (i < 3)); end
            tick();
        end
        checks++;
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL burst_extra_beat: valid %b, required 0", readdatavalid); end
        wait_drain("burst_wrap");
    endtask

    task automatic test_byteenable();
        write_burst(8'h20, 1, '1, '1);
        write_burst(8'h20, 1, 16'h0001, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CD5A);
        checks++;
        if (mem_m[8'h20] !== {{15{8'hFF}}, 8'h5A}) begin errors++; $display("FAIL be_model: got %h, required %h", mem_m[8'h20], {{15{8'hFF}}, 8'h5A}); end
        read_cmd(8'h20, 1);
        wait_drain("byteenable");
    endtask

    task automatic test_freeze();
        logic              s_vld;
        logic [DATA_W-1:0] s_rd;
        write_burst(8'h40, 8, '1, 128'hF00D_0000_0000_0000_0000_0000_0000_0040);
        read_cmd(8'h40, 8);
        tick();
        freeze = 1'b1;
        s_vld = readdatavalid;
        s_rd  = readdata;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (waitrequest !== 1'b1) begin errors++; $display("FAIL freeze_waitrequest cyc %0d: got %b, required 1", i, waitrequest); end
            if (i > 0) begin
                checks += 2;
                if (readdatavalid !== s_vld) begin errors++; $display("FAIL freeze_valid_hold cyc %0d: got %b, required %b", i, readdatavalid, s_vld); end
                if (readdata !== s_rd) begin errors++; $display("FAIL freeze_data_hold cyc %0d: got %h, required %h", i, readdata, s_rd); end
            end
            tick();
        end
        freeze = 1'b0;
        wait_drain("freeze");
    endtask

    task automatic test_back_to_back();
        int budget = 10;
        write_burst(8'h60, 4, '1, 128'hBEEF_0000_0000_0000_0000_0000_0000_0060);
        read_cmd(8'h60, 4);
        while (waitrequest && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_idle: waitrequest %b, required 0", waitrequest); end
        write_burst(8'h63, 1, '1, 128'hCAFE_CAFE_CAFE_CAFE_CAFE_CAFE_CAFE_CAFE);
        wait_drain("b2b_inflight");
        read_cmd(8'h63, 1);
        wait_drain("b2b_new");
    endtask

    task automatic test_reset_mid();
        write_burst(8'h80, 8, '1, 128'hD00D_0000_0000_0000_0000_0000_0000_0080);
        read_cmd(8'h80, 8);
        tick();
        reset_n = 1'b0;
        #1;
        checks += 3;
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rstmid_valid1: got %b, required 0", readdatavalid); end
        if (readdatavalid2 !== 1'b0) begin errors++; $display("FAIL rstmid_valid2: got %b, required 0", readdatavalid2); end
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL rstmid_waitrequest: got %b, required 1", waitrequest); end
        exp_q1.delete();
        exp_q2.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (waitrequest !== 1'b0) begin errors++; $display("FAIL rstmid_fsm_idle cyc %0d: waitrequest %b, required 0", i, waitrequest); end
            if (readdatavalid !== 1'b0 || readdatavalid2 !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stray_beat cyc %0d: valid %b/%b, required 0/0", i, readdatavalid, readdatavalid2);
            end
            tick();
        end
        read_cmd(8'h80, 8);
        wait_drain("rstmid_retained");
    endtask

    task automatic test_parity();
        write_burst(8'h05, 1, '1, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
`ifdef ONCHIP_RAM_PARITY_EN
        dut.u_core.mem[5][8]  = ~dut.u_core.mem[5][8];
        dut2.u_core.mem[5][8] = ~dut2.u_core.mem[5][8];
        perr_expect = 1'b1;
`endif
        read_cmd(8'h05, 1);
        wait_drain("parity");
        perr_expect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_byteenable();
        test_freeze();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
